// File: rtl/drive_command_encoder.sv
// Drive command encoder: turns debounced direction keys and a torque selector
// into a ramped enable/direction/torque bundle with estop lockout.
module drive_command_encoder #(
    parameter int unsigned STEP_CYCLES = 12_500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_fwd,
    input  logic       key_rev,
    input  logic       key_left,
    input  logic       key_right,
    input  logic [1:0] torque_sel,
    input  logic       estop,
    output logic       enable,
    output logic [1:0] direc,
    output logic [1:0] torque,
    output logic       cmd_valid
);

    localparam int unsigned CNT_W = $clog2(STEP_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_RAMP_UP   = 2'd1,
        S_RUN       = 2'd2,
        S_RAMP_DOWN = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic             enable_q, enable_d;
    logic [1:0]       direc_q, direc_d;
    logic [1:0]       torque_q, torque_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic             lock_q, lock_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       key_any;
    logic [1:0] req_dir;
    logic [1:0] tgt;
    logic       tick;
    logic       dir_ok;
    logic       go_down;

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            enable_q    <= 1'b0;
            direc_q     <= 2'b00;
            torque_q    <= 2'b00;
            cmd_valid_q <= 1'b0;
            lock_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            enable_q    <= enable_d;
            direc_q     <= direc_d;
            torque_q    <= torque_d;
            cmd_valid_q <= cmd_valid_d;
            lock_q      <= lock_d;
            cnt_q       <= cnt_d;
        end
    end

    // Request decode, next-state and next-output logic
    always_comb begin
        key_any = key_fwd | key_rev | key_left | key_right;
        if (key_fwd)       req_dir = 2'b00;
        else if (key_rev)  req_dir = 2'b01;
        else if (key_left) req_dir = 2'b10;
        else               req_dir = 2'b11;
        tgt     = key_any ? torque_sel : 2'd0;
        tick    = (cnt_q == CNT_LAST);
        dir_ok  = (req_dir == direc_q);
        go_down = !key_any || !dir_ok || (tgt < torque_q) || (tgt == 2'd0);

        state_d  = state_q;
        enable_d = enable_q;
        direc_d  = direc_q;
        torque_d = torque_q;
        lock_d   = lock_q;

        case (state_q)
            S_IDLE: begin
                enable_d = 1'b0;
                torque_d = 2'd0;
                if (key_any && (tgt != 2'd0) && !lock_q) begin
                    direc_d  = req_dir;
                    enable_d = 1'b1;
                    state_d  = S_RAMP_UP;
                end
            end
            S_RAMP_UP: begin
                if (go_down) begin
                    state_d = S_RAMP_DOWN;
                end else if (torque_q == tgt) begin
                    state_d = S_RUN;
                end else if (tick && (torque_q != 2'd3)) begin
                    torque_d = torque_q + 2'd1;
                end
            end
            S_RUN: begin
                if (go_down) begin
                    state_d = S_RAMP_DOWN;
                end else if (tgt > torque_q) begin
                    state_d = S_RAMP_UP;
                end
            end
            S_RAMP_DOWN: begin
                // Direction may only change once torque has reached zero
                if (torque_q == 2'd0) begin
                    enable_d = 1'b0;
                    state_d  = S_IDLE;
                end else if (key_any && dir_ok && (tgt == torque_q)) begin
                    state_d = S_RUN;
                end else if (key_any && dir_ok && (tgt > torque_q)) begin
                    state_d = S_RAMP_UP;
                end else if (tick) begin
                    torque_d = torque_q - 2'd1;
                    if (torque_q == 2'd1) begin
                        enable_d = 1'b0;
                        state_d  = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Estop overrides everything and latches a lock until keys are released
        if (estop) begin
            state_d  = S_IDLE;
            enable_d = 1'b0;
            torque_d = 2'd0;
            lock_d   = 1'b1;
        end else if (!key_any) begin
            lock_d = 1'b0;
        end

        if ((state_d != state_q) || (state_q == S_IDLE) || (state_q == S_RUN) || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        cmd_valid_d = (enable_d != enable_q) || (direc_d != direc_q) || (torque_d != torque_q);
    end

    assign enable    = enable_q;
    assign direc     = direc_q;
    assign torque    = torque_q;
    assign cmd_valid = cmd_valid_q;

endmodule

// File: tb/tb_drive_command_encoder.sv
// Directed self-checking bench for drive_command_encoder with STEP_CYCLES=4.
module tb_drive_command_encoder;

    localparam int unsigned STEP = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_fwd, key_rev, key_left, key_right;
    logic [1:0] torque_sel;
    logic       estop;
    logic       enable;
    logic [1:0] direc;
    logic [1:0] torque;
    logic       cmd_valid;

    int n_checks = 0;
    int n_fail   = 0;

    drive_command_encoder #(.STEP_CYCLES(STEP)) dut (
        .clk        (clk),
        .reset      (reset),
        .key_fwd    (key_fwd),
        .key_rev    (key_rev),
        .key_left   (key_left),
        .key_right  (key_right),
        .torque_sel (torque_sel),
        .estop      (estop),
        .enable     (enable),
        .direc      (direc),
        .torque     (torque),
        .cmd_valid  (cmd_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got {en,dir,tq,cv}=%b expected %b", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] obs();
        return {enable, direc, torque, cmd_valid};
    endfunction

    function automatic logic [5:0] ev(input int en, input int dir, input int tq, input int cv);
        return {1'(en), 2'(dir), 2'(tq), 1'(cv)};
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_keys(input logic f, input logic r, input logic l, input logic rt);
        key_fwd   = f;
        key_rev   = r;
        key_left  = l;
        key_right = rt;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        tick();
        tick();
        check(tag, obs(), ev(0, 0, 0, 0));
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        estop = 1'b0;
        torque_sel = 2'd3;
        set_keys(1, 0, 0, 0);

        // 1: reset with fwd held, ramp to 3
        do_reset("t1_reset");
        tick();
        check("t1_start", obs(), ev(1, 0, 0, 1));
        for (int k = 1; k <= 16; k++) begin
            tick();
            check($sformatf("t1_k%0d", k), obs(),
                  ev(1, 0, imin(k / 4, 3), ((k % 4 == 0) && (k <= 12)) ? 1 : 0));
        end

        // 3: reversal fwd@3 -> rev@3
        set_keys(0, 1, 0, 0);
        for (int k = 0; k <= 27; k++) begin
            tick();
            if (k <= 12) begin
                check($sformatf("t3_down%0d", k), obs(),
                      ev((k < 12) ? 1 : 0, 0, 3 - k / 4, ((k >= 4) && (k % 4 == 0)) ? 1 : 0));
            end else begin
                int j;
                j = k - 13;
                check($sformatf("t3_up%0d", j), obs(),
                      ev(1, 1, imin(j / 4, 3), ((j == 0) || ((j % 4 == 0) && (j <= 12))) ? 1 : 0));
            end
        end

        // 2: rev+left priority -> rev, ramp to 2, then raise to 3
        set_keys(0, 1, 1, 0);
        torque_sel = 2'd2;
        do_reset("t2_reset");
        tick();
        check("t2_start", obs(), ev(1, 1, 0, 1));
        for (int k = 1; k <= 10; k++) begin
            tick();
            check($sformatf("t2_k%0d", k), obs(),
                  ev(1, 1, imin(k / 4, 2), ((k == 4) || (k == 8)) ? 1 : 0));
        end
        torque_sel = 2'd3;
        for (int j = 0; j <= 5; j++) begin
            tick();
            check($sformatf("t2_raise%0d", j), obs(), ev(1, 1, (j >= 4) ? 3 : 2, (j == 4) ? 1 : 0));
        end

        // 4: release at 2, re-press right at 1
        set_keys(1, 0, 0, 0);
        torque_sel = 2'd2;
        do_reset("t4_reset");
        for (int k = 0; k <= 9; k++) tick();
        check("t4_run", obs(), ev(1, 0, 2, 0));
        set_keys(0, 0, 0, 0);
        for (int r = 0; r <= 18; r++) begin
            int etq, een, edir, ecv;
            tick();
            if (r <= 8) begin
                etq  = (r < 4) ? 2 : ((r < 8) ? 1 : 0);
                een  = (r < 8) ? 1 : 0;
                edir = 0;
                ecv  = ((r == 4) || (r == 8)) ? 1 : 0;
            end else begin
                etq  = imin((r - 9) / 4, 2);
                een  = 1;
                edir = 3;
                ecv  = ((r == 9) || (r == 13) || (r == 17)) ? 1 : 0;
            end
            check($sformatf("t4_r%0d", r), obs(), ev(een, edir, etq, ecv));
            if (r == 4) set_keys(0, 0, 0, 1);
        end

        // 5: estop at torque 3 with keys held, lockout, then clean restart
        set_keys(1, 0, 0, 0);
        torque_sel = 2'd3;
        do_reset("t5_reset");
        for (int k = 0; k <= 14; k++) tick();
        check("t5_run", obs(), ev(1, 0, 3, 0));
        estop = 1'b1;
        tick();
        check("t5_estop", obs(), ev(0, 0, 0, 1));
        estop = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("t5_lock%0d", k), obs(), ev(0, 0, 0, 0));
        end
        set_keys(0, 0, 0, 0);
        tick();
        check("t5_release", obs(), ev(0, 0, 0, 0));
        set_keys(1, 0, 0, 0);
        tick();
        check("t5_restart", obs(), ev(1, 0, 0, 1));

        // 6: zero target holds off start
        torque_sel = 2'd0;
        do_reset("t6_reset");
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("t6_zero%0d", k), obs(), ev(0, 0, 0, 0));
        end
        torque_sel = 2'd1;
        tick();
        check("t6_start", obs(), ev(1, 0, 0, 1));
        for (int k = 1; k <= 6; k++) begin
            tick();
            check($sformatf("t6_k%0d", k), obs(), ev(1, 0, (k >= 4) ? 1 : 0, (k == 4) ? 1 : 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/drive_command_encoder.md
# drive_command_encoder

Produces the drive command bundle (`enable`, `direc[1:0]`, `torque[1:0]`) that the torque LED display and motor stage consume. It reads debounced direction keys and a target-torque selector, and ramps torque one level per step period. Direction is only changed at zero torque. It sits between the board input conditioning and every consumer of the drive command.

## Interface
- `STEP_CYCLES`, default 12_500_000: clock cycles per torque step (250 ms at 50 MHz); minimum 2.
- `clk` input 1: system clock; the only clock.
- `reset` input 1: synchronous, active-high reset.
- `key_fwd`, `key_rev`, `key_left`, `key_right` input 1 each: held-level direction requests; already debounced and synchronised.
- `torque_sel` input 2: target torque level, 0..3.
- `estop` input 1: emergency stop, level-sensitive.
- `enable` output 1: drive enabled.
- `direc` output 2: direction. 00 fwd, 01 rev, 10 left, 11 right.
- `torque` output 2: current torque level, 0..3.
- `cmd_valid` output 1: 1-cycle pulse when any of `enable`/`direc`/`torque` changes.

## Operation
- Requested direction `req_dir` is a priority encode of the keys: fwd > rev > left > right. `key_any` = OR of all keys.
- Effective target `tgt` = `torque_sel` if `key_any`, else 0.
- Step tick: a counter runs 0..STEP_CYCLES-1 only in RAMP_UP and RAMP_DOWN. A tick fires when it equals STEP_CYCLES-1, then the counter wraps to 0. The counter clears on every state change and in IDLE and RUN.
- **IDLE**: `enable`=0, `torque`=0, `direc` holds its last value.
  - If `key_any` and `tgt`≠0 and not locked: `direc`<=`req_dir`, `enable`<=1, go to RAMP_UP.
- **RAMP_UP**:
  - On a tick, `torque`+1.
  - When `torque`==`tgt`, go to RUN on the next edge.
  - If `tgt`<`torque`, or `req_dir`≠`direc`, or !`key_any`, go to RAMP_DOWN immediately. The counter clears.
- **RUN**: `torque`==`tgt`.
  - If `tgt`>`torque` and `req_dir`==`direc`, go to RAMP_UP.
  - If `tgt`<`torque`, or `req_dir`≠`direc`, or !`key_any`, go to RAMP_DOWN.
- **RAMP_DOWN**:
  - On a tick, `torque`-1.
  - On reaching 0, `enable`<=0 and go to IDLE. IDLE re-evaluates next cycle, so a direction change costs 1 idle cycle before the ramp starts.
  - If `torque`==`tgt`≠0 and `req_dir`==`direc`, go to RUN.
  - If `tgt`>`torque` and `req_dir`==`direc`, go to RAMP_UP.
- Torque saturates at 3 and never underflows below 0.
- **estop**: highest priority below reset. Same edge: `torque`<=0, `enable`<=0, state<=IDLE, lock<=1.
  - Lock clears only on a cycle with `estop`=0 and `key_any`=0.
  - IDLE cannot leave while locked.
- `cmd_valid` is registered. It is 1 in exactly the cycle where the new `enable`/`direc`/`torque` values are first visible, and 0 otherwise.
- **Reset**: state IDLE, `enable`=0, `direc`=00, `torque`=00, `cmd_valid`=0, counter 0, lock 0.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- IDLE to `enable`=1: 1 edge after a qualifying request. `torque` is still 0 on that edge; `cmd_valid` pulses.
- First torque increment: STEP_CYCLES edges after entering RAMP_UP. Each further level adds STEP_CYCLES edges.
- Ramp 0→3: 1 + 3·STEP_CYCLES edges from the request to `torque`=3.
- Full reversal 3 fwd → 3 rev: 3·STEP_CYCLES (down) + 1 (IDLE) + 1 (start) + 3·STEP_CYCLES (up).
- `estop`: outputs are zero 1 edge after `estop` is sampled high, regardless of counter phase.
- A `reset` mid-ramp overrides everything on that edge.
- Simultaneous `estop` and a change in `tgt`: `estop` wins.

## Test plan
Bench uses STEP_CYCLES=4.
1. **Reset**: hold `key_fwd`=1, `torque_sel`=3 through `reset` → all outputs 0 during reset. First cycle after release: `enable`=1, `direc`=00, `torque`=0, `cmd_valid`=1. `torque`=1/2/3 at +4/+8/+12 cycles, each with a single `cmd_valid` pulse, then RUN.
2. **Priority**: `key_rev`+`key_left` pressed, `torque_sel`=2 → `direc`=01, ramp to 2, hold. Raise `torque_sel` to 3 → `torque`=3 after 4 cycles.
3. **Reversal**: running fwd at 3, switch to `key_rev` only → `torque` goes 2,1,0 at 4-cycle spacing with `direc`=00 and `enable`=0 at 0. One IDLE cycle later `direc`=01 and `enable`=1, then ramp to 3. `direc` never changes while `torque`≠0.
4. **Release and re-press**: at `torque`=2, release all keys → ramp down to 0, `enable`=0. Re-press `key_right` at `torque`=1 → ramp continues to 0 first, then `direc`=11 and ramp up.
5. **Estop**: assert `estop` for 1 cycle mid-step at `torque`=3 with keys held → next edge `torque`=0, `enable`=0, `cmd_valid`=1. Outputs stay 0 while keys are held. Release all keys, then press `key_fwd` → normal start.
6. **Zero target**: `torque_sel`=0 with `key_fwd` held → `enable` stays 0 and `cmd_valid` never pulses. Change to 1 → start on the next edge.
